gray_mem_arbiter: RTL

- Shares the single gray-image memory port (gray_req / gray_addr / gray_ready / gray_data) between two pixel-fetch engines.
- Typical pairing: the LBP engine and a second neighbourhood filter.
- Round-robin arbitration with a grant lock and a bounded burst length, so an engine that holds its request high forever (as the LBP engine does) cannot starve the other.
- Sits between the engines and the testbench/ROM memory model; memory read is combinational (data valid in the same cycle as the address).

---
 rtl/gray_arb_pkg.sv | 35 +++
 rtl/rr_pick2.sv | 22 ++
 rtl/gray_mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gray_arb_pkg.sv
// Shared definitions for the gray-image memory arbiter: state encoding,
// default bus widths shared with the LBP engine, and small state helpers.
package gray_arb_pkg;

  // Bus widths: a 128x128 image of 8-bit gray pixels.
  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 8;

  // Width of the burst counter. MAX_BURST-1 is truncated to this width.
  localparam int BURST_W = 8;

  // Arbiter state encoding.
  localparam logic [1:0] ST_WAIT_RDY = 2'd0;
  localparam logic [1:0] ST_IDLE     = 2'd1;
  localparam logic [1:0] ST_OWN0     = 2'd2;
  localparam logic [1:0] ST_OWN1     = 2'd3;

  typedef enum logic [1:0] {
    WAIT_RDY = ST_WAIT_RDY,
    IDLE     = ST_IDLE,
    OWN0     = ST_OWN0,
    OWN1     = ST_OWN1
  } arb_state_e;

  // True while one of the two requesters owns the memory port.
  function automatic logic is_owner_state(input arb_state_e s);
    return (s == OWN0) || (s == OWN1);
  endfunction

  // Ownership state for requester id (0 or 1).
  function automatic arb_state_e own_state(input logic id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector. When both requesters ask at
// once, the one that did not own the port last time wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic winner,
  output logic valid
);

  // Pick a winner; a tie goes to the requester that is not last_owner.
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_owner;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/gray_mem_arbiter.sv
// Shares the single gray-image memory port between two pixel-fetch
// engines. Round-robin with a grant lock: an owner keeps the port while it
// requests, but is forced to hand over after a bounded burst when the other
// engine is waiting. Memory reads are combinational, so data from the
// memory is passed straight back to both requesters.
module gray_mem_arbiter
  import gray_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_gnt,
  output logic [DATA_W-1:0] r0_data,
  output logic              r0_ready,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r1_gnt,
  output logic [DATA_W-1:0] r1_data,
  output logic              r1_ready,
  output logic              busy
);

  // Last granted-cycle count of a burst before a forced handoff, and the
  // saturation value of the counter.
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [BURST_W-1:0] BURST_SAT  = BURST_W'(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic               last_owner_q, last_owner_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               rdy_seen_q, rdy_seen_d;

  logic pick_winner;
  logic pick_valid;
  logic own_id;
  logic own_req;
  logic oth_req;

  rr_pick2 u_pick (
    .req0       (r0_req),
    .req1       (r1_req),
    .last_owner (last_owner_q),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // Current owner's request and the other requester's request; only
  // meaningful in the OWN states.
  assign own_id  = (state_q == OWN1);
  assign own_req = own_id ? r1_req : r0_req;
  assign oth_req = own_id ? r0_req : r1_req;

  // Next-state logic: ready bring-up, idle pick, burst counting and handoff.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    rdy_seen_d   = rdy_seen_q;
    case (state_q)
      WAIT_RDY: begin
        if (gray_ready) begin
          state_d    = IDLE;
          rdy_seen_d = 1'b1;
        end
      end
      IDLE: begin
        burst_cnt_d = '0;
        if (pick_valid) begin
          state_d = own_state(pick_winner);
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          // Voluntary release: pass to the waiting engine or go idle.
          last_owner_d = own_id;
          burst_cnt_d  = '0;
          state_d      = oth_req ? own_state(~own_id) : IDLE;
        end else if (oth_req && (burst_cnt_q >= BURST_LAST)) begin
          // Burst limit reached with the other engine waiting. A counter
          // that saturated during a solo burst also hands over at once.
          last_owner_d = own_id;
          burst_cnt_d  = '0;
          state_d      = own_state(~own_id);
        end else if (burst_cnt_q < BURST_SAT) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = WAIT_RDY;
      end
    endcase
  end

  // Port muxing: only the owner reaches the memory; all zero otherwise.
  always_comb begin
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    gray_req  = 1'b0;
    gray_addr = '0;
    busy      = is_owner_state(state_q);
    case (state_q)
      OWN0: begin
        r0_gnt    = r0_req;
        gray_req  = r0_req;
        gray_addr = r0_addr;
      end
      OWN1: begin
        r1_gnt    = r1_req;
        gray_req  = r1_req;
        gray_addr = r1_addr;
      end
      default: begin
        gray_req  = 1'b0;
      end
    endcase
  end

  assign r0_data  = gray_data;
  assign r1_data  = gray_data;
  assign r0_ready = rdy_seen_q;
  assign r1_ready = rdy_seen_q;

  // State, ownership history, burst counter and ready flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= WAIT_RDY;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      rdy_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rdy_seen_q   <= rdy_seen_d;
    end
  end

endmodule
